obu_word_aligner: RTL and testbench

//  Upstream feeder for obu_header_parser and the other parsers that share its data_in/avail/pop/pad contract.

---
 rtl/obu_parser_pkg.sv | 26 ++
 rtl/obu_word_aligner_byte_window_shift.sv | 40 ++++
 rtl/obu_word_aligner.sv | 171 +++++++++++++++++
 tb/tb_obu_word_aligner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/obu_parser_pkg.sv
// rtl/obu_parser_pkg.sv - shared parser widths and word aligner constants
//
// Purpose: common constants for the OBU parsers and their upstream word aligner.
// Ports: none (package).
package obu_parser_pkg;

  localparam int PARSER_DATA_WIDTH = 32;

  // pad may discard up to one word plus one trailing byte
  localparam int PAD_LEN_MAX   = PARSER_DATA_WIDTH + 8;
  localparam int PAD_LEN_WIDTH = $clog2(PAD_LEN_MAX + 1);

  localparam int ALIGN_BUF_WORDS = 3;
  localparam int ALIGN_BUF_WIDTH = ALIGN_BUF_WORDS * PARSER_DATA_WIDTH;
  localparam int ALIGN_LVL_WIDTH = $clog2(ALIGN_BUF_WIDTH + 1);

  // outstanding skip is held in bytes; the counter saturates instead of wrapping
  localparam int ALIGN_SKIP_BYTES_WIDTH = 13;

  typedef enum logic [1:0] {
    CONS_NONE = 2'd0,
    CONS_POP  = 2'd1,
    CONS_PAD  = 2'd2
  } align_cons_e;

endpackage

// File: rtl/obu_word_aligner_byte_window_shift.sv
// rtl/obu_word_aligner_byte_window_shift.sv - byte-granular shift right / insert at offset
//
// Purpose: dout = base | ((din >> 8*shr) masked to keep bytes) << 8*off.
//   Used once to consume from the window and once to splice an input word into it.
//   base must be zero wherever the shifted data lands.
// Ports:
//   base  in  WIDTH   data the shifted bytes are OR-ed into
//   din   in  WIDTH   data to shift
//   shr   in  CNT_W   bytes dropped from the bottom of din
//   keep  in  CNT_W   bytes of the shifted din that survive
//   off   in  CNT_W   byte offset the surviving bytes land at
//   dout  out WIDTH   result
module byte_window_shift #(
  parameter int WIDTH = 96,
  parameter int CNT_W = $clog2(WIDTH / 8 + 1)
) (
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] shr,
  input  logic [CNT_W-1:0] keep,
  input  logic [CNT_W-1:0] off,
  output logic [WIDTH-1:0] dout
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (CNT_W'(i) < keep) mask[8*i +: 8] = 8'hFF;
    end
  end

  assign shifted = (din >> {shr, 3'b000}) & mask;
  assign dout    = base | (shifted << {off, 3'b000});

endmodule

// File: rtl/obu_word_aligner.sv
// rtl/obu_word_aligner.sv - byte-granular sliding window feeding the OBU parsers
//
// Purpose: accepts byte-packed words and always presents the oldest W bits of the
//   stream on data_in (earliest byte in [7:0]). pop retires W bits, pad retires
//   pad_len bits; pad beyond the buffered data turns into skip of future input.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_nbytes/in_valid input word, valid byte count (low bytes), valid
//   in_ready                   room for a full word (level <= BUF_W-W)
//   flush                      synchronous clear of window, level, skip, proto_err
//   data_in                    window[W-1:0], bytes beyond level read 0
//   avail                      level >= W
//   pop                        consume W bits (only while avail)
//   pad/pad_len                consume pad_len bits (byte multiple, 0..W+8)
//   proto_err                  sticky protocol violation flag
module obu_word_aligner
  import obu_parser_pkg::*;
#(
  parameter int W         = PARSER_DATA_WIDTH,
  parameter int BUF_WORDS = ALIGN_BUF_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             in_data,
  input  logic [$clog2(W/8):0]     in_nbytes,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [W-1:0]             data_in,
  output logic                     avail,
  input  logic                     pop,
  input  logic                     pad,
  input  logic [PAD_LEN_WIDTH-1:0] pad_len,
  output logic                     proto_err
);

  localparam int BUF_W = BUF_WORDS * W;
  localparam int WB    = W / 8;
  localparam int BB    = BUF_W / 8;
  localparam int LVL_W = $clog2(BUF_W + 1);
  localparam int CNT_W = $clog2(BB + 1);
  localparam int NBY_W = $clog2(WB) + 1;
  localparam int SKB_W = ALIGN_SKIP_BYTES_WIDTH;
  localparam int SKT_W = SKB_W + 1;

  logic [BUF_W-1:0] window;
  logic [BUF_W-1:0] cons_win;
  logic [BUF_W-1:0] ins_win;
  logic [BUF_W-1:0] in_ext;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic [SKB_W-1:0] skip_bytes;
  logic [SKB_W-1:0] skip_nxt;
  logic             proto_err_q;

  align_cons_e      cons_sel;
  logic             err_set;
  logic             pad_len_bad;
  logic             pad_len_big;
  logic             accept;
  logic [CNT_W-1:0] level_b;
  logic [CNT_W-1:0] pad_b;
  logic [CNT_W-1:0] cons_b;
  logic [CNT_W-1:0] skip_add_b;
  logic [CNT_W-1:0] in_b;
  logic [CNT_W-1:0] drop_b;
  logic [CNT_W-1:0] wr_b;
  logic [CNT_W-1:0] off_b;
  logic [SKT_W-1:0] skip_tot;
  logic [SKT_W-1:0] skip_rem;

  // all handshake outputs come straight from registered state
  assign avail     = level >= LVL_W'(W);
  assign in_ready  = level <= LVL_W'(BUF_W - W);
  assign data_in   = window[W-1:0];
  assign proto_err = proto_err_q;
  assign accept    = in_valid && in_ready;
  assign level_b   = CNT_W'(level >> 3);
  assign in_ext    = BUF_W'(in_data);

  // out-of-range pad lengths are truncated to a byte boundary, then saturated
  assign pad_len_big = pad_len > PAD_LEN_WIDTH'(W + 8);
  assign pad_len_bad = (pad_len[2:0] != 3'b000) || pad_len_big;
  assign pad_b       = pad_len_big ? CNT_W'(WB + 1) : CNT_W'(pad_len >> 3);

  always_comb begin
    cons_sel   = CONS_NONE;
    err_set    = 1'b0;
    cons_b     = '0;
    skip_add_b = '0;

    if (pop) begin
      if (avail) cons_sel = CONS_POP;
      else       err_set  = 1'b1;
      if (pad)   err_set  = 1'b1;
    end else if (pad) begin
      cons_sel = CONS_PAD;
    end
    if (pad && pad_len_bad) err_set = 1'b1;

    case (cons_sel)
      CONS_POP: cons_b = CNT_W'(WB);
      CONS_PAD: begin
        // padding past the buffered data is remembered as skip of future bytes
        if (pad_b > level_b) begin
          cons_b     = level_b;
          skip_add_b = pad_b - level_b;
        end else begin
          cons_b = pad_b;
        end
      end
      default: ;
    endcase

    if (accept) in_b = (in_nbytes > NBY_W'(WB)) ? CNT_W'(WB) : CNT_W'(in_nbytes);
    else        in_b = '0;

    // skip created by this cycle's pad already applies to a word arriving now
    skip_tot = {1'b0, skip_bytes} + SKT_W'(skip_add_b);
    drop_b   = (skip_tot >= SKT_W'(in_b)) ? in_b : CNT_W'(skip_tot);
    wr_b     = in_b - drop_b;
    off_b    = level_b - cons_b;
    skip_rem = skip_tot - SKT_W'(drop_b);
    skip_nxt = skip_rem[SKB_W] ? '1 : skip_rem[SKB_W-1:0];
    level_nxt = LVL_W'({off_b + wr_b, 3'b000});
  end

  byte_window_shift #(
    .WIDTH (BUF_W),
    .CNT_W (CNT_W)
  ) u_consume (
    .base  ('0),
    .din   (window),
    .shr   (cons_b),
    .keep  (CNT_W'(BB)),
    .off   ('0),
    .dout  (cons_win)
  );

  byte_window_shift #(
    .WIDTH (BUF_W),
    .CNT_W (CNT_W)
  ) u_insert (
    .base  (cons_win),
    .din   (in_ext),
    .shr   (drop_b),
    .keep  (wr_b),
    .off   (off_b),
    .dout  (ins_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window      <= '0;
      level       <= '0;
      skip_bytes  <= '0;
      proto_err_q <= 1'b0;
    end else if (flush) begin
      window      <= '0;
      level       <= '0;
      skip_bytes  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      window     <= ins_win;
      level      <= level_nxt;
      skip_bytes <= skip_nxt;
      if (err_set) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obu_word_aligner.sv
// tb/tb_obu_word_aligner.sv - directed self-checking bench for obu_word_aligner
module tb_obu_word_aligner;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] data_in;
  logic        avail;
  logic        pop;
  logic        pad;
  logic [5:0]  pad_len;
  logic        proto_err;

  int total;
  int bad;

  obu_word_aligner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_in   (data_in),
    .avail     (avail),
    .pop       (pop),
    .pad       (pad),
    .pad_len   (pad_len),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] nb);
    in_data   = d;
    in_nbytes = nb;
    in_valid  = 1'b1;
    cyc();
    in_valid  = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    cyc();
    pop = 1'b0;
  endtask

  task automatic do_pad(input logic [5:0] len);
    pad     = 1'b1;
    pad_len = len;
    cyc();
    pad     = 1'b0;
    pad_len = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    pop       = 1'b0;
    pad       = 1'b0;
    pad_len   = '0;
    cyc();
    cyc();

    // reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_avail", 32'(avail), 32'd0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: two full words, avail one cycle after the first, pop advances
    push(32'h44332211, 3'd4);
    chk("t1_avail_after_w1", 32'(avail), 32'd1);
    chk("t1_data_w1", data_in, 32'h44332211);
    push(32'h88776655, 3'd4);
    chk("t1_data_hold", data_in, 32'h44332211);
    do_pop();
    chk("t1_data_after_pop", data_in, 32'h88776655);
    chk("t1_avail_after_pop", 32'(avail), 32'd1);
    do_pop();
    chk("t1_empty_avail", 32'(avail), 32'd0);
    chk("t1_empty_data", data_in, 32'h0);

    // 2: fill to 96 bits, in_ready drops, refused word, one pop reopens
    push(32'h03020100, 3'd4);
    push(32'h07060504, 3'd4);
    chk("t2_ready_lvl64", 32'(in_ready), 32'd1);
    push(32'h0B0A0908, 3'd4);
    chk("t2_ready_lvl96", 32'(in_ready), 32'd0);
    push(32'h0F0E0D0C, 3'd4);
    chk("t2_refused_data", data_in, 32'h03020100);
    do_pop();
    chk("t2_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t2_data_after_pop", data_in, 32'h07060504);
    do_pop();
    chk("t2_data_third", data_in, 32'h0B0A0908);
    do_flush();
    chk("t2_flush_avail", 32'(avail), 32'd0);

    // 3: pad 16 bits from a 64-bit window
    push(32'h44332211, 3'd4);
    push(32'h88776655, 3'd4);
    do_pad(6'd16);
    chk("t3_pad_data", data_in, 32'h66554433);
    chk("t3_pad_avail", 32'(avail), 32'd1);
    chk("t3_pad_err", 32'(proto_err), 32'd0);
    do_pop();
    chk("t3_lvl48_pop_data", data_in, 32'h00008877);
    chk("t3_lvl48_pop_avail", 32'(avail), 32'd0);

    // 4: level 16, pad 40 -> 24 bits of skip into the next word
    do_pad(6'd40);
    chk("t4_pad_over_data", data_in, 32'h0);
    chk("t4_pad_over_err", 32'(proto_err), 32'd0);
    push(32'hDDCCBBAA, 3'd4);
    chk("t4_skip_data", data_in, 32'h000000DD);
    chk("t4_skip_avail", 32'(avail), 32'd0);
    do_flush();

    // 5: partial word then full word
    push(32'hFFFF2211, 3'd2);
    chk("t5_partial_data", data_in, 32'h00002211);
    chk("t5_partial_avail", 32'(avail), 32'd0);
    push(32'h66554433, 3'd4);
    chk("t5_joined_data", data_in, 32'h44332211);
    chk("t5_joined_avail", 32'(avail), 32'd1);
    do_pop();
    chk("t5_lvl48_pop_data", data_in, 32'h00006655);
    do_flush();

    // 6: protocol errors, pad limits, flush, async reset
    do_pop();
    chk("t6_pop_empty_err", 32'(proto_err), 32'd1);
    chk("t6_pop_empty_data", data_in, 32'h0);
    chk("t6_pop_empty_ready", 32'(in_ready), 32'd1);
    do_flush();
    chk("t6_flush_err", 32'(proto_err), 32'd0);

    push(32'h44332211, 3'd4);
    push(32'h88776655, 3'd4);
    pop = 1'b1;
    pad = 1'b1;
    pad_len = 6'd16;
    cyc();
    pop = 1'b0;
    pad = 1'b0;
    pad_len = '0;
    chk("t6_pop_pad_data", data_in, 32'h88776655);
    chk("t6_pop_pad_err", 32'(proto_err), 32'd1);

    // flush with a word offered in the same cycle discards it
    in_data   = 32'h12345678;
    in_nbytes = 3'd4;
    in_valid  = 1'b1;
    flush     = 1'b1;
    cyc();
    in_valid  = 1'b0;
    flush     = 1'b0;
    chk("t6_flush_data", data_in, 32'h0);
    chk("t6_flush_avail", 32'(avail), 32'd0);
    chk("t6_flush_err_clr", 32'(proto_err), 32'd0);

    push(32'h44332211, 3'd4);
    do_pad(6'd12);
    chk("t6_pad12_data", data_in, 32'h00443322);
    chk("t6_pad12_err", 32'(proto_err), 32'd1);
    do_flush();

    push(32'h44332211, 3'd4);
    push(32'h88776655, 3'd4);
    do_pad(6'd40);
    chk("t6_pad40_data", data_in, 32'h00887766);
    chk("t6_pad40_err", 32'(proto_err), 32'd0);
    do_flush();

    push(32'h44332211, 3'd4);
    push(32'h88776655, 3'd4);
    do_pad(6'd56);
    chk("t6_pad56_data", data_in, 32'h00887766);
    chk("t6_pad56_err", 32'(proto_err), 32'd1);

    // asynchronous reset mid-stream
    push(32'h11111111, 3'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_data", data_in, 32'h0);
    chk("t6_arst_avail", 32'(avail), 32'd0);
    chk("t6_arst_ready", 32'(in_ready), 32'd1);
    chk("t6_arst_err", 32'(proto_err), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push(32'hCAFEBABE, 3'd4);
    chk("t6_head_data", data_in, 32'hCAFEBABE);
    chk("t6_head_avail", 32'(avail), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
